timer_unit: RTL and testbench

TIMER_UNIT -- requirements
Module: timer_unit

---
 rtl/timer_unit_if.sv | 26 ++
 rtl/timer_unit.sv | 121 ++++++++++++
 tb/tb_timer_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/timer_unit_if.sv
// Bus bundle for timer_unit: load/control inputs and status outputs.
// The expiry strobe is called evt because "event" is a reserved word in SystemVerilog.
interface timer_unit_if #(
  parameter int WIDTH     = 8,
  parameter int PRE_WIDTH = 8
);
  logic [WIDTH-1:0]     value;
  logic [1:0]           mode;
  logic                 put;
  logic                 cancel;
  logic [PRE_WIDTH-1:0] prescale;
  logic                 out;
  logic                 evt;
  logic                 busy;
  logic [WIDTH-1:0]     count;

  modport master (
    output value, mode, put, cancel, prescale,
    input  out, evt, busy, count
  );

  modport slave (
    input  value, mode, put, cancel, prescale,
    output out, evt, busy, count
  );
endinterface

// File: rtl/timer_unit.sv
// Down-counting timer with alarm/strobe/pulse/timeout modes and registered outputs.
// Define TIMER_UNIT_PRESCALE_EN to divide ticks by (latched prescale + 1).
module timer_unit #(
  parameter int WIDTH     = 8,
  parameter int PRE_WIDTH = 8
) (
  input logic         clock,
  input logic         reset,
  timer_unit_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  localparam logic [1:0] M_ALARM  = 2'd0;
  localparam logic [1:0] M_STROBE = 2'd1;
  localparam logic [1:0] M_PULSE  = 2'd2;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     count_q, count_d;
  logic [WIDTH-1:0]     load_q, load_d;
  logic [1:0]           mode_q, mode_d;
  logic [PRE_WIDTH-1:0] pre_q, pre_d;
  logic [PRE_WIDTH-1:0] pcnt_q, pcnt_d;
  logic                 evt_q, evt_d;
  logic                 out_q, out_d;
  logic                 busy_q, busy_d;
  logic                 tick;

`ifdef TIMER_UNIT_PRESCALE_EN
  assign tick = (pcnt_q == pre_q);
`else
  // Every RUN clock is a tick; the prescaler state is kept but unused here.
  logic unused_prescale;
  assign unused_prescale = ^{pre_q, pcnt_q};
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    load_d  = load_q;
    mode_d  = mode_q;
    pre_d   = pre_q;
    pcnt_d  = pcnt_q;
    evt_d   = 1'b0;

    if (bus.cancel) begin
      state_d = ST_IDLE;
      count_d = '0;
      pcnt_d  = '0;
    end else if (bus.put) begin
      pcnt_d = '0;
      if (bus.value != '0) begin
        state_d = ST_RUN;
        count_d = bus.value;
        load_d  = bus.value;
        mode_d  = bus.mode;
        pre_d   = bus.prescale;
      end else begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    end else if (state_q == ST_RUN) begin
      if (tick) begin
        pcnt_d = '0;
        if (count_q == WIDTH'(1)) begin
          evt_d = 1'b1;
          if (mode_q == M_STROBE) begin
            count_d = load_q;
          end else if (mode_q == M_PULSE) begin
            count_d = '0;
            state_d = ST_IDLE;
          end else begin
            count_d = '0;
            state_d = ST_DONE;
          end
        end else begin
          count_d = count_q - 1'b1;
        end
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end

    busy_d = (state_d == ST_RUN);
    // Timeout mode is the only one that parks in DONE with out held high.
    unique case (mode_d)
      M_ALARM, M_STROBE: out_d = evt_d;
      M_PULSE:           out_d = (state_d == ST_RUN);
      default:           out_d = (state_d == ST_DONE);
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      load_q  <= '0;
      mode_q  <= '0;
      pre_q   <= '0;
      pcnt_q  <= '0;
      evt_q   <= 1'b0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      load_q  <= load_d;
      mode_q  <= mode_d;
      pre_q   <= pre_d;
      pcnt_q  <= pcnt_d;
      evt_q   <= evt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.evt   = evt_q;
  assign bus.out   = out_q;
  assign bus.busy  = busy_q;
  assign bus.count = count_q;
endmodule

// File: tb/tb_timer_unit.sv
// Self-checking bench for timer_unit: expiry-time reference model plus directed literal checks.
module tb_timer_unit;
`ifdef TIMER_UNIT_PRESCALE_EN
  localparam int PRESC = 1;
`else
  localparam int PRESC = 0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  timer_unit_if #(.WIDTH(8), .PRE_WIDTH(8)) bus ();
  timer_unit #(.WIDTH(8), .PRE_WIDTH(8)) dut (.clock(clock), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int evt_edges[$];
  int out_edges[$];

  // Reference: a running timer is described by its start edge, length and tick period.
  bit m_run, m_done, m_evt;
  int m_start, m_n, m_mode, m_per, m_count;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    int el;
    m_evt = 1'b0;
    if (reset) begin
      m_run = 0; m_done = 0; m_mode = 0; m_per = 1;
    end else if (bus.cancel) begin
      m_run = 0; m_done = 0;
    end else if (bus.put) begin
      m_done = 0;
      if (bus.value != 0) begin
        m_run = 1; m_start = cyc; m_n = int'(bus.value); m_mode = int'(bus.mode);
        m_per = PRESC ? int'(bus.prescale) + 1 : 1;
      end else begin
        m_run = 0;
      end
    end else if (m_run) begin
      el = cyc - m_start;
      if (el % (m_n * m_per) == 0) begin
        m_evt = 1'b1;
        if (m_mode != 1) begin
          m_run = 0;
          m_done = (m_mode == 0 || m_mode == 3);
        end
      end
    end
    m_count = m_run ? m_n - (((cyc - m_start) / m_per) % m_n) : 0;
  endtask

  task automatic step();
    int exp_out;
    @(posedge clock);
    cyc++;
    model_step();
    #1;
    exp_out = (m_mode == 2) ? int'(m_run) : (m_mode == 3) ? int'(m_done) : int'(m_evt);
    chk("evt",   int'(bus.evt),   int'(m_evt));
    chk("busy",  int'(bus.busy),  int'(m_run));
    chk("count", int'(bus.count), m_count);
    chk("out",   int'(bus.out),   exp_out);
    if (bus.evt) evt_edges.push_back(cyc);
    if (bus.out) out_edges.push_back(cyc);
    @(negedge clock);
  endtask

  task automatic idle(int n);
    bus.put = 0; bus.cancel = 0; reset = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_put(int v, int m, int p, output int pe);
    bus.put = 1; bus.value = 8'(v); bus.mode = 2'(m); bus.prescale = 8'(p);
    pe = cyc + 1;
    step();
    bus.put = 0;
  endtask

  function automatic int n_in(int q[$], int a, int b);
    int n = 0;
    foreach (q[i]) if (q[i] >= a && q[i] <= b) n++;
    return n;
  endfunction

  function automatic int first_in(int q[$], int a);
    foreach (q[i]) if (q[i] >= a) return q[i] - a;
    return -1;
  endfunction

  initial begin
    int pe, pe2;
    reset = 1; bus.put = 0; bus.cancel = 0; bus.value = 0; bus.mode = 0; bus.prescale = 0;
    @(negedge clock);
    for (int i = 0; i < 3; i++) step();
    chk("reset_count", int'(bus.count), 0);
    chk("reset_busy",  int'(bus.busy), 0);
    chk("reset_out",   int'(bus.out), 0);
    chk("reset_evt",   int'(bus.evt), 0);
    idle(2);

    // Alarm, 0x11
    do_put(8'h11, 0, 0, pe); idle(20);
    chk("alarm_lat",   first_in(evt_edges, pe), 17);
    chk("alarm_nevt",  n_in(evt_edges, pe, pe + 20), 1);
    chk("alarm_nout",  n_in(out_edges, pe, pe + 20), 1);
    chk("alarm_busy",  int'(bus.busy), 0);
    chk("alarm_count", int'(bus.count), 0);

    // Strobe 7, then cancel
    do_put(7, 1, 0, pe); idle(21);
    chk("strobe_first", first_in(evt_edges, pe), 7);
    chk("strobe_nevt",  n_in(evt_edges, pe, pe + 21), 3);
    bus.cancel = 1; step(); idle(15);
    chk("strobe_cancel_nevt", n_in(evt_edges, pe + 22, pe + 37), 0);
    chk("strobe_cancel_out",  int'(bus.out), 0);

    // Pulse 5
    do_put(5, 2, 0, pe); idle(12);
    chk("pulse_nout", n_in(out_edges, pe, pe + 12), 5);

    // Timeout 5, held until next put
    do_put(5, 3, 0, pe); idle(30);
    chk("timeout_rise", first_in(out_edges, pe), 5);
    chk("timeout_hold", int'(bus.out), 1);
    do_put(0, 0, 0, pe); idle(2);
    chk("timeout_clear", int'(bus.out), 0);

    // value 0
    do_put(0, 0, 0, pe); idle(5);
    chk("zero_nevt", n_in(evt_edges, pe, pe + 5), 0);
    chk("zero_busy", int'(bus.busy), 0);

    // 0xFF
    do_put(8'hFF, 0, 0, pe); idle(260);
    chk("ff_lat", first_in(evt_edges, pe), 255);

    // put coinciding with expiry
    do_put(10, 0, 0, pe); idle(9);
    do_put(3, 0, 0, pe2);
    chk("coincide_count", int'(bus.count), 3);
    idle(6);
    chk("coincide_first", first_in(evt_edges, pe), 13);
    chk("coincide_nevt",  n_in(evt_edges, pe, pe + 16), 1);

    // reset at +3 of a 10-count run
    do_put(10, 0, 0, pe); idle(2);
    reset = 1; step(); idle(15);
    chk("reset_mid_nevt", n_in(evt_edges, pe, pe + 20), 0);

    // prescale retrigger (prescale ignored in the default build)
    do_put(4, 0, 2, pe); idle(5);
    do_put(1, 0, 2, pe2); idle(10);
    chk("presc_first", first_in(evt_edges, pe), PRESC ? 9 : 4);
    chk("presc_nevt",  n_in(evt_edges, pe, pe + 16), PRESC ? 1 : 2);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      bus.cancel = ($urandom_range(0, 31) == 0);
      bus.put    = ($urandom_range(0, 7) == 0);
      bus.value  = ($urandom_range(0, 49) == 0) ? 8'hFF : 8'($urandom_range(0, 12));
      bus.mode   = 2'($urandom_range(0, 3));
      bus.prescale = 8'($urandom_range(0, 3));
      step();
    end
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
